// File: rtl/ls_pkg.sv
// Shared types and defaults for the load/store burst sequencer: state encoding,
// strobe bundle and the state-to-strobe decode.
package ls_pkg;

  localparam int unsigned DefaultMaxBurst      = 4;
  localparam int unsigned DefaultTimeoutCycles = 15;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StLdWait,
    StLdWb,
    StStData,
    StStWait,
    StNext,
    StDone,
    StErr
  } ls_state_t;

  typedef struct packed {
    logic reg_out;
    logic reg_in;
    logic mar_in_en;
    logic mar_inc;
    logic mdr_in_en;
    logic mdr_out_en;
    logic mem_en;
    logic rw;
    logic pc_inc;
    logic done;
    logic error;
  } ls_strobes_t;

  function automatic ls_strobes_t ls_decode(ls_state_t st);
    ls_strobes_t s;
    s = '0;
    unique case (st)
      StIdle:   ;
      StAddr:   begin s.reg_out = 1'b1; s.mar_in_en = 1'b1; end
      StLdWait: begin s.mem_en = 1'b1; s.rw = 1'b1; s.mdr_in_en = 1'b1; end
      StLdWb:   begin s.mdr_out_en = 1'b1; s.reg_in = 1'b1; end
      StStData: begin s.reg_out = 1'b1; s.mdr_in_en = 1'b1; end
      StStWait: s.mem_en = 1'b1;
      StNext:   s.mar_inc = 1'b1;
      StDone:   begin s.done = 1'b1; s.pc_inc = 1'b1; end
      StErr:    begin s.error = 1'b1; s.done = 1'b1; end
      default:  ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ls_wait_timer.sv
// MFC wait timer: counts low-MFC cycles in a wait state and flags the cycle in which
// the limit is reached. Only built with LS_TIMEOUT_EN.
`ifdef LS_TIMEOUT_EN
module ls_wait_timer
  import ls_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Fires during the TIMEOUT_CYCLES-th consecutive low-MFC cycle.
  assign expired = count_en && (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/load_store_burst_ctrl.sv
// Burst load/store sequencer (Moore FSM, registered strobes, auto-incrementing MAR).
// Optional MFC wait timeout enabled by defining LS_TIMEOUT_EN.
module load_store_burst_ctrl
  import ls_pkg::*;
#(
  parameter int unsigned MAX_BURST      = DefaultMaxBurst,
  parameter int unsigned CNT_W          = $clog2(MAX_BURST),
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Load,
  input  logic [CNT_W-1:0] BurstLen,
  input  logic             MFC,
  output logic             RegOut,
  output logic             RegIn,
  output logic             MAR_inEn,
  output logic             MAR_Inc,
  output logic             MDR_inEn,
  output logic             OutEnMDROut,
  output logic             Enable,
  output logic             RW,
  output logic [CNT_W-1:0] BeatIdx,
  output logic             PC_Increment,
  output logic             Done,
  output logic             Error
);

  if ((MAX_BURST < 2) || ((MAX_BURST & (MAX_BURST - 1)) != 0) || (TIMEOUT_CYCLES < 1))
  begin : g_bad_cfg
    $error("load_store_burst_ctrl: unsupported MAX_BURST/TIMEOUT_CYCLES");
  end

  ls_state_t       state_q, state_d;
  logic            load_q, load_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  ls_strobes_t     strb_q, strb_d;
  logic            last_beat;
  logic            in_wait;
  logic            expired;

  assign last_beat = (beat_q == len_q);
  assign in_wait   = (state_q == StLdWait) || (state_q == StStWait);

`ifdef LS_TIMEOUT_EN
  ls_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_wait),
    .count_en(in_wait && !MFC),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    len_d   = len_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StAddr;
          load_d  = Load;
          len_d   = BurstLen;
          beat_d  = '0;
        end
      end
      StAddr:   state_d = load_q ? StLdWait : StStData;
      StLdWait: begin
        if (MFC) begin
          state_d = StLdWb;
        end else if (expired) begin
          state_d = StErr;
        end
      end
      StLdWb:   state_d = last_beat ? StDone : StNext;
      StStData: state_d = StStWait;
      StStWait: begin
        if (MFC) begin
          state_d = last_beat ? StDone : StNext;
        end else if (expired) begin
          state_d = StErr;
        end
      end
      StNext: begin
        state_d = load_q ? StLdWait : StStData;
        beat_d  = beat_q + CNT_W'(1);
      end
      StDone:   state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Strobes are registered from the next state so they line up with state_q.
    strb_d = ls_decode(state_d);
`ifndef LS_TIMEOUT_EN
    strb_d.error = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      load_q  <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      strb_q  <= strb_d;
    end
  end

  assign RegOut       = strb_q.reg_out;
  assign RegIn        = strb_q.reg_in;
  assign MAR_inEn     = strb_q.mar_in_en;
  assign MAR_Inc      = strb_q.mar_inc;
  assign MDR_inEn     = strb_q.mdr_in_en;
  assign OutEnMDROut  = strb_q.mdr_out_en;
  assign Enable       = strb_q.mem_en;
  assign RW           = strb_q.rw;
  assign PC_Increment = strb_q.pc_inc;
  assign Done         = strb_q.done;
  assign Error        = strb_q.error;
  assign BeatIdx      = beat_q;

endmodule

// File: tb/tb_load_store_burst_ctrl.sv
// Bench for load_store_burst_ctrl: per-cycle vectors of inputs and expected state,
// expected strobes queued at drive time and compared mid-cycle.
module tb_load_store_burst_ctrl;

  localparam int CntW = 2;
  localparam int SIdle = 0, SAddr = 1, SLdWait = 2, SLdWb = 3, SStData = 4;
  localparam int SStWait = 5, SNext = 6, SDone = 7, SErr = 8;

  typedef struct {
    logic            rst;
    logic            start;
    logic            load;
    logic [CntW-1:0] blen;
    logic            mfc;
    int              st;
    logic [CntW-1:0] beat;
  } vec_t;

  typedef struct {
    logic [10:0]     outs;
    logic [CntW-1:0] beat;
    int              idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic            clk = 1'b0;
  logic            reset, Start, Load, MFC;
  logic [CntW-1:0] BurstLen;
  logic            RegOut, RegIn, MAR_inEn, MAR_Inc, MDR_inEn, OutEnMDROut;
  logic            Enable, RW, PC_Increment, Done, Error;
  logic [CntW-1:0] BeatIdx;

  always #5 clk = ~clk;

  load_store_burst_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .Start       (Start),
    .Load        (Load),
    .BurstLen    (BurstLen),
    .MFC         (MFC),
    .RegOut      (RegOut),
    .RegIn       (RegIn),
    .MAR_inEn    (MAR_inEn),
    .MAR_Inc     (MAR_Inc),
    .MDR_inEn    (MDR_inEn),
    .OutEnMDROut (OutEnMDROut),
    .Enable      (Enable),
    .RW          (RW),
    .BeatIdx     (BeatIdx),
    .PC_Increment(PC_Increment),
    .Done        (Done),
    .Error       (Error)
  );

  // Order: RegOut RegIn MAR_inEn MAR_Inc MDR_inEn OutEnMDROut Enable RW PC_Inc Done Error
  function automatic logic [10:0] outs_for(int st);
    case (st)
      SAddr:   return 11'b101_0000_0000;
      SLdWait: return 11'b000_0101_1000;
      SLdWb:   return 11'b010_0010_0000;
      SStData: return 11'b100_0100_0000;
      SStWait: return 11'b000_0001_0000;
      SNext:   return 11'b000_1000_0000;
      SDone:   return 11'b000_0000_0110;
      SErr:    return 11'b000_0000_0011;
      default: return 11'b000_0000_0000;
    endcase
  endfunction

  task automatic add(input logic r, input logic s, input logic l, input logic [CntW-1:0] b,
                     input logic m, input int st, input logic [CntW-1:0] beat);
    vecs.push_back('{rst: r, start: s, load: l, blen: b, mfc: m, st: st, beat: beat});
  endtask

  initial begin
    exp_t            e;
    logic [10:0]     got;

    // Reset state
    add(1, 0, 0, 0, 0, SIdle, 0);
    // Single load, MFC on first wait cycle: Done in cycle 4
    add(0, 1, 1, 0, 0, SIdle,   0);
    add(0, 0, 0, 0, 0, SAddr,   0);
    add(0, 0, 0, 0, 1, SLdWait, 0);
    add(0, 0, 0, 0, 1, SLdWb,   0);
    add(0, 0, 0, 0, 0, SDone,   0);
    // Store burst of 4 started right after DONE; Load/BurstLen wiggle mid-burst
    add(0, 1, 0, 3, 0, SIdle,   0);
    add(0, 0, 1, 0, 1, SAddr,   0);
    for (int b = 0; b < 4; b++) begin
      add(0, 0, 1, 0, 1, SStData, CntW'(b));
      add(0, 0, 1, 0, 1, SStWait, CntW'(b));
      if (b < 3) add(0, 0, 1, 0, 1, SNext, CntW'(b));
    end
    add(0, 1, 1, 0, 0, SDone, 3);
    // Single load, MFC 5 cycles late: LD_WAIT for 6 cycles, Done in cycle 9
    add(0, 1, 1, 0, 0, SIdle, 3);
    add(0, 0, 0, 3, 0, SAddr, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 3, 0, SLdWait, 0);
    add(0, 0, 0, 0, 1, SLdWait, 0);
    add(0, 0, 0, 0, 1, SLdWb,   0);
    add(0, 0, 0, 0, 0, SDone,   0);
    add(0, 0, 0, 0, 1, SIdle,   0);
    add(0, 0, 0, 0, 0, SIdle,   0);
    // Store burst, reset in ST_WAIT of beat 2 with Start held
    add(0, 1, 0, 3, 0, SIdle, 0);
    add(0, 0, 0, 3, 0, SAddr, 0);
    for (int b = 0; b < 2; b++) begin
      add(0, 0, 0, 3, 1, SStData, CntW'(b));
      add(0, 0, 0, 3, 1, SStWait, CntW'(b));
      add(0, 0, 0, 3, 1, SNext,   CntW'(b));
    end
    add(0, 0, 0, 3, 0, SStData, 2);
    add(1, 1, 0, 3, 0, SStWait, 2);
    add(1, 1, 1, 1, 0, SIdle,   0);
    // Start accepted on the first cycle out of reset: 2-beat load
    add(0, 1, 1, 1, 0, SIdle,   0);
    add(0, 0, 0, 0, 0, SAddr,   0);
    add(0, 0, 0, 0, 1, SLdWait, 0);
    add(0, 0, 0, 0, 0, SLdWb,   0);
    add(0, 0, 0, 0, 0, SNext,   0);
    add(0, 0, 0, 0, 1, SLdWait, 1);
    add(0, 0, 0, 0, 0, SLdWb,   1);
    add(0, 0, 0, 0, 0, SDone,   1);
    // Store with MFC held low
    add(0, 1, 0, 0, 0, SIdle,   1);
    add(0, 0, 0, 0, 0, SAddr,   0);
    add(0, 0, 0, 0, 0, SStData, 0);
`ifdef LS_TIMEOUT_EN
    for (int k = 0; k < 15; k++) add(0, 0, 0, 0, 0, SStWait, 0);
    add(0, 0, 0, 0, 0, SErr,  0);
    add(0, 0, 0, 0, 0, SIdle, 0);
    add(0, 0, 0, 0, 0, SIdle, 0);
`else
    for (int k = 0; k < 110; k++) add(0, 0, 0, 0, 0, SStWait, 0);
    add(0, 0, 0, 0, 1, SStWait, 0);
    add(0, 0, 0, 0, 0, SDone,   0);
    add(0, 0, 0, 0, 0, SIdle,   0);
`endif

    reset = 1'b1; Start = 1'b0; Load = 1'b0; BurstLen = '0; MFC = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset    = vecs[i].rst;
      Start    = vecs[i].start;
      Load     = vecs[i].load;
      BurstLen = vecs[i].blen;
      MFC      = vecs[i].mfc;
      sb_q.push_back('{outs: outs_for(vecs[i].st), beat: vecs[i].beat, idx: i});
      @(negedge clk);
      e   = sb_q.pop_front();
      got = {RegOut, RegIn, MAR_inEn, MAR_Inc, MDR_inEn, OutEnMDROut, Enable, RW,
             PC_Increment, Done, Error};
      n_checks++;
      if (got !== e.outs) begin
        n_fail++;
        $display("FAIL strobes vec %0d: got %b expected %b", e.idx, got, e.outs);
      end
      n_checks++;
      if (BeatIdx !== e.beat) begin
        n_fail++;
        $display("FAIL beat_idx vec %0d: got %0d expected %0d", e.idx, BeatIdx, e.beat);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
